// File: rtl/resta_serial.sv
// Bit-serial subtractor: R = A - B over M clocks, LSB first, with N/Z/C/V flags
// and a start/busy/done handshake. Results are only updated on entry to DONE.
module resta_serial #(
  parameter int unsigned M = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [M-1:0] A,
  input  logic [M-1:0] B,
  output logic [M-1:0] R,
  output logic         N,
  output logic         Z,
  output logic         C,
  output logic         V,
  output logic         busy,
  output logic         done
);

  localparam int unsigned CntW = (M > 1) ? $clog2(M) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(M - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q, state_d;
  logic [M-1:0]    sa_q, sb_q;
  // Only M-1 result bits need storing; the final bit is merged in on the last cycle.
  logic [M-2:0]    sr_q;
  logic [M-1:0]    sr_next;
  logic [CntW-1:0] cnt_q;
  logic            bw_q, bw_next, d;
  logic            a_msb_q, b_msb_q;
  logic            accept, last;

  always_comb begin
    d       = sa_q[0] ^ sb_q[0] ^ bw_q;
    bw_next = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & bw_q);
    sr_next = {d, sr_q};
    last    = (cnt_q == CntLast);
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    accept  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          accept  = 1'b1;
          state_d = StRun;
        end
      end
      StRun: begin
        busy = 1'b1;
        if (last) state_d = StDone;
      end
      StDone: begin
        done = 1'b1;
        if (start) begin
          accept  = 1'b1;
          state_d = StRun;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sa_q    <= '0;
      sb_q    <= '0;
      sr_q    <= '0;
      bw_q    <= 1'b0;
      cnt_q   <= '0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      R       <= '0;
      N       <= 1'b0;
      Z       <= 1'b0;
      C       <= 1'b0;
      V       <= 1'b0;
    end else if (accept) begin
      sa_q    <= A;
      sb_q    <= B;
      bw_q    <= 1'b0;
      cnt_q   <= '0;
      a_msb_q <= A[M-1];
      b_msb_q <= B[M-1];
    end else if (state_q == StRun) begin
      sa_q  <= sa_q >> 1;
      sb_q  <= sb_q >> 1;
      sr_q  <= sr_next[M-1:1];
      bw_q  <= bw_next;
      cnt_q <= cnt_q + CntW'(1);
      if (last) begin
        R <= sr_next;
        C <= bw_next;
        N <= sr_next[M-1];
        Z <= (sr_next == '0);
        V <= (a_msb_q ^ b_msb_q) & (sr_next[M-1] ^ a_msb_q);
      end
    end
  end

endmodule

// File: tb/tb_resta_serial.sv
// Bench for resta_serial: M=4 and M=8 instances checked every cycle against an
// arithmetic model, plus literal expectations for the directed cases.
module tb_resta_serial;

  logic       clk;
  logic [1:0] rst, start;
  logic [7:0] a [2];
  logic [7:0] b [2];
  logic [3:0] r4;
  logic [7:0] r8;
  logic [1:0] n, z, c, v, busy, done;

  int errors = 0;
  int checks = 0;
  bit armed  = 0;

  // Model state per instance
  bit          m_busy [2];
  bit          m_done [2];
  int          m_left [2];
  int unsigned m_r    [2];
  logic [3:0]  m_f    [2];
  int unsigned p_r    [2];
  logic [3:0]  p_f    [2];

  resta_serial #(.M(4)) dut4 (
    .clk(clk), .rst(rst[0]), .start(start[0]), .A(a[0][3:0]), .B(b[0][3:0]),
    .R(r4), .N(n[0]), .Z(z[0]), .C(c[0]), .V(v[0]), .busy(busy[0]), .done(done[0])
  );

  resta_serial #(.M(8)) dut8 (
    .clk(clk), .rst(rst[1]), .start(start[1]), .A(a[1]), .B(b[1]),
    .R(r8), .N(n[1]), .Z(z[1]), .C(c[1]), .V(v[1]), .busy(busy[1]), .done(done[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int width(input int k);
    return (k == 0) ? 4 : 8;
  endfunction

  function automatic int unsigned dut_r(input int k);
    return (k == 0) ? {28'd0, r4} : {24'd0, r8};
  endfunction

  // Expected result and {N,Z,C,V} from plain arithmetic on the operands.
  task automatic model_sub(input int w, input int unsigned av, input int unsigned bv,
                           output int unsigned res, output logic [3:0] f);
    int unsigned mask, am, bm, rm;
    mask = (32'd1 << w) - 1;
    am   = av & mask;
    bm   = bv & mask;
    res  = (am - bm) & mask;
    rm   = res >> (w - 1);
    f[3] = rm[0];
    f[2] = (res == 0);
    f[1] = (am < bm);
    f[0] = (((am >> (w - 1)) & 1) != ((bm >> (w - 1)) & 1)) &&
           (rm != ((am >> (w - 1)) & 1));
  endtask

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst[k]) begin
        m_busy[k] = 0; m_done[k] = 0; m_left[k] = 0; m_r[k] = 0; m_f[k] = 4'b0;
      end else if (m_busy[k]) begin
        m_left[k] = m_left[k] - 1;
        if (m_left[k] == 0) begin
          m_busy[k] = 0; m_done[k] = 1; m_r[k] = p_r[k]; m_f[k] = p_f[k];
        end
      end else if (start[k]) begin
        model_sub(width(k), {24'd0, a[k]}, {24'd0, b[k]}, p_r[k], p_f[k]);
        m_busy[k] = 1; m_done[k] = 0; m_left[k] = width(k);
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      for (int k = 0; k < 2; k++) begin
        checks++;
        if ({busy[k], done[k]} !== {m_busy[k], m_done[k]}) begin
          errors++;
          $display("FAIL model_busy_done[%0d] t=%0t: got %b%b want %b%b", k, $time,
                   busy[k], done[k], m_busy[k], m_done[k]);
        end
        checks++;
        if (dut_r(k) !== m_r[k]) begin
          errors++;
          $display("FAIL model_R[%0d] t=%0t: got %0h want %0h", k, $time, dut_r(k), m_r[k]);
        end
        checks++;
        if ({n[k], z[k], c[k], v[k]} !== m_f[k]) begin
          errors++;
          $display("FAIL model_NZCV[%0d] t=%0t: got %b want %b", k, $time,
                   {n[k], z[k], c[k], v[k]}, m_f[k]);
        end
      end
    end
  end

  task automatic lit(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Accept an operation, scramble the operand inputs, then check the handshake
  // timing and the final result against hand-computed values.
  task automatic run_op(input int k, input logic [7:0] av, input logic [7:0] bv,
                        input int unsigned exp_r, input logic [3:0] exp_f,
                        input string name);
    a[k] = av; b[k] = bv; start[k] = 1'b1;
    @(posedge clk); #1;
    start[k] = 1'b0;
    a[k] = ~av; b[k] = av ^ bv;
    lit({name, "_busy_after_accept"}, {30'd0, busy[k], done[k]}, 2);
    repeat (width(k) - 1) @(posedge clk);
    #1;
    lit({name, "_busy_last"}, {30'd0, busy[k], done[k]}, 2);
    @(posedge clk); #1;
    lit({name, "_done"}, {30'd0, busy[k], done[k]}, 1);
    lit({name, "_R"}, dut_r(k), exp_r);
    lit({name, "_NZCV"}, {28'd0, n[k], z[k], c[k], v[k]}, {28'd0, exp_f});
  endtask

  task automatic mid_reset(input int k, input string name);
    a[k] = 8'h06; b[k] = 8'h02; start[k] = 1'b1;
    @(posedge clk); #1;
    start[k] = 1'b0;
    @(posedge clk); #1;
    rst[k] = 1'b1;
    @(posedge clk); #1;
    rst[k] = 1'b0;
    lit({name, "_busy_done"}, {30'd0, busy[k], done[k]}, 0);
    lit({name, "_R"}, dut_r(k), 0);
    lit({name, "_NZCV"}, {28'd0, n[k], z[k], c[k], v[k]}, 0);
  endtask

  initial begin
    rst = 2'b11; start = 2'b00;
    a[0] = 8'h0; b[0] = 8'h0; a[1] = 8'h0; b[1] = 8'h0;
    repeat (2) @(posedge clk);
    #1;
    rst = 2'b00;
    armed = 1;
    lit("reset4_R", dut_r(0), 0);
    lit("reset4_flags", {26'd0, busy[0], done[0], n[0], z[0], c[0], v[0]}, 0);
    lit("reset8_R", dut_r(1), 0);

    run_op(0, 8'd7, 8'd3, 4,  4'b0000, "plain");
    run_op(0, 8'd3, 8'd7, 12, 4'b1010, "borrow");
    run_op(0, 8'd8, 8'd1, 7,  4'b0001, "ovf");
    run_op(0, 8'd5, 8'd5, 0,  4'b0100, "equal");
    run_op(0, 8'd0, 8'd1, 15, 4'b1010, "from_done");

    // start pulsed two cycles into RUN with different operands must be ignored
    a[0] = 8'd9; b[0] = 8'd2; start[0] = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    a[0] = 8'd1; b[0] = 8'd1; start[0] = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0;
    lit("start_in_run_busy", {30'd0, busy[0], done[0]}, 2);
    @(posedge clk); #1;
    lit("start_in_run_done", {30'd0, busy[0], done[0]}, 1);
    lit("start_in_run_R", dut_r(0), 7);

    mid_reset(0, "midrst4");
    run_op(0, 8'd6, 8'd2, 4, 4'b0000, "after_rst4");

    run_op(1, 8'h80, 8'h01, 8'h7F, 4'b0001, "m8_ovf");
    run_op(1, 8'h10, 8'h20, 8'hF0, 4'b1010, "m8_borrow");
    mid_reset(1, "midrst8");
    run_op(1, 8'h80, 8'h01, 8'h7F, 4'b0001, "after_rst8");

    repeat (3) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
